// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, ALUOp, mux selects.
// Pure declarations and decode helpers, no state; the ALU imports the same ALUOp constants.
// CTRL_JAL_EN: when defined, jal/jr become legal opcodes that complete in ID.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] DST_R31 = 2'b00;
    localparam logic [1:0] DST_RT  = 2'b01;
    localparam logic [1:0] DST_RD  = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

`ifdef CTRL_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    // jal/jr exist only in builds with the link-jump feature
    function automatic logic op_is_link(input logic [5:0] op);
        return JAL_EN && ((op == OP_JAL) || (op == OP_JR));
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT,
            OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT: return 1'b1;
            OP_JAL, OP_JR:                       return JAL_EN;
            default:                             return 1'b0;
        endcase
    endfunction

    // instructions whose last state is ID (illegal opcodes run as a two-cycle nop)
    function automatic logic op_ends_in_id(input logic [5:0] op);
        return !op_is_legal(op) || (op == OP_J) || op_is_link(op);
    endfunction

    function automatic logic op_is_rtype(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
               (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
    endfunction

    function automatic logic op_uses_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] op_alu(input logic [5:0] op);
        case (op)
            OP_SUB, OP_BEQ: return ALU_SUB;
            OP_OR, OP_ORI:  return ALU_OR;
            OP_AND:         return ALU_AND;
            OP_SLL:         return ALU_SLL;
            OP_SLT:         return ALU_SLT;
            default:        return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/zero from the datapath, control strobes back.
// Wires only, no latency; master is the controller, slave is the datapath.
// No flow control: the datapath consumes the strobes every cycle.
interface multi_cycle_ctrl_if;
    import multi_cycle_ctrl_pkg::*;

    logic [5:0] opcode;
    logic       zero;
    logic [2:0] ALUOp;
    logic       PCWre;
    logic       IRWre;
    logic       RegWre;
    logic       ALUSrcB;
    logic       DataMemRW;
    logic       DBDataSrc;
    logic       WrRegData;
    logic [1:0] RegDst;
    logic [1:0] PCSrc;
    logic       ExtSel;
    state_t     state;

    modport master (
        input  opcode, zero,
        output ALUOp, PCWre, IRWre, RegWre, ALUSrcB, DataMemRW,
               DBDataSrc, WrRegData, RegDst, PCSrc, ExtSel, state
    );

    modport slave (
        output opcode, zero,
        input  ALUOp, PCWre, IRWre, RegWre, ALUSrcB, DataMemRW,
               DBDataSrc, WrRegData, RegDst, PCSrc, ExtSel, state
    );
endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Control-strobe decode from current FSM state and opcode (jal/jr handled when CTRL_JAL_EN).
// Purely combinational: zero latency from state/opcode/zero to strobes.
// No backpressure; unnamed strobes default to 0 in every state.
module ctrl_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] ALUOp,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       ALUSrcB,
    output logic       DataMemRW,
    output logic       DBDataSrc,
    output logic       WrRegData,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic       ExtSel
);

    // per-state strobe decode; ALU controls held from EXE through WB so the result stays put
    always_comb begin
        ALUOp     = ALU_ADD;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        ALUSrcB   = 1'b0;
        DataMemRW = 1'b0;
        DBDataSrc = 1'b0;
        WrRegData = 1'b0;
        RegDst    = DST_R31;
        PCSrc     = PC_SEQ;
        ExtSel    = 1'b0;

        if ((state == ST_EXE) || (state == ST_MEM) || (state == ST_WB)) begin
            ALUOp   = op_alu(opcode);
            ALUSrcB = op_uses_imm(opcode);
            ExtSel  = (opcode != OP_ORI);
        end

        case (state)
            ST_IF: IRWre = 1'b1;
            ST_ID: begin
                if (op_is_link(opcode)) begin
                    PCWre = 1'b1;
                    PCSrc = (opcode == OP_JAL) ? PC_JMP : PC_REG;
                    if (opcode == OP_JAL) begin
                        RegWre    = 1'b1;
                        RegDst    = DST_R31;
                        WrRegData = 1'b0;
                    end
                end else if (op_ends_in_id(opcode)) begin
                    PCWre = 1'b1;
                    if (opcode == OP_J) PCSrc = PC_JMP;
                end
            end
            ST_EXE: begin
                if (opcode == OP_BEQ) begin
                    PCWre = 1'b1;
                    if (zero) PCSrc = PC_BR;
                end
            end
            ST_MEM: begin
                if (opcode == OP_SW) begin
                    PCWre     = 1'b1;
                    DataMemRW = 1'b1;
                end
            end
            ST_WB: begin
                PCWre     = 1'b1;
                RegWre    = 1'b1;
                WrRegData = 1'b1;
                DBDataSrc = (opcode == OP_LW);
                RegDst    = op_is_rtype(opcode) ? DST_RD : DST_RT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: IF/ID/EXE/MEM/WB/HALT state register plus next-state logic.
// State advances one step per CLK; strobes come from ctrl_decode with zero latency.
// No backpressure; HALT is left only through RST (asynchronous, active-high). Macro: CTRL_JAL_EN.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    multi_cycle_ctrl_if.master bus
);

    state_t state;

    // instruction sequencing: path through the states is chosen by opcode in ID/EXE/MEM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IF;
        end else begin
            case (state)
                ST_IF:  state <= ST_ID;
                ST_ID: begin
                    if (bus.opcode == OP_HALT)          state <= ST_HALT;
                    else if (op_ends_in_id(bus.opcode)) state <= ST_IF;
                    else                                state <= ST_EXE;
                end
                ST_EXE: begin
                    if (bus.opcode == OP_BEQ)                              state <= ST_IF;
                    else if ((bus.opcode == OP_SW) || (bus.opcode == OP_LW)) state <= ST_MEM;
                    else                                                   state <= ST_WB;
                end
                ST_MEM: state <= (bus.opcode == OP_SW) ? ST_IF : ST_WB;
                ST_WB:   state <= ST_IF;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IF;
            endcase
        end
    end

    assign bus.state = state;

    ctrl_decode u_decode (
        .state     (state),
        .opcode    (bus.opcode),
        .zero      (bus.zero),
        .ALUOp     (bus.ALUOp),
        .PCWre     (bus.PCWre),
        .IRWre     (bus.IRWre),
        .RegWre    (bus.RegWre),
        .ALUSrcB   (bus.ALUSrcB),
        .DataMemRW (bus.DataMemRW),
        .DBDataSrc (bus.DBDataSrc),
        .WrRegData (bus.WrRegData),
        .RegDst    (bus.RegDst),
        .PCSrc     (bus.PCSrc),
        .ExtSel    (bus.ExtSel)
    );

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed instructions, randomized opcode/zero stream, halt and resets.
// Expected values come from a per-instruction state path plus rule-based strobe table.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_multi_cycle_ctrl;

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010,
                           S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b111;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010,
                           OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010,
                           SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000,
                           LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000,
                           JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

    localparam logic [5:0] OPS [14] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                                        SW, LW, BEQ, J, JAL, JR};

`ifdef CTRL_JAL_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    int   vectors = 0;
    int   miscompares = 0;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [14:0] observed_ctl();
        return {bus.ALUOp, bus.PCWre, bus.IRWre, bus.RegWre, bus.ALUSrcB, bus.DataMemRW,
                bus.DBDataSrc, bus.WrRegData, bus.RegDst, bus.PCSrc, bus.ExtSel};
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        foreach (OPS[k]) if (OPS[k] == op) return ((op != JAL) && (op != JR)) || JAL_ON;
        return op == HALT;
    endfunction

    function automatic bit rtype(input logic [5:0] op);
        return op == ADD || op == SUB || op == OR_ || op == AND_ || op == SLL || op == SLT;
    endfunction

    // number of states the instruction occupies before returning to IF (halt: up to ID)
    function automatic int path_len(input logic [5:0] op);
        if (!known_op(op) || op == J || op == JAL || op == JR || op == HALT) return 2;
        if (op == BEQ) return 3;
        if (op == LW) return 5;
        return 4;
    endfunction

    function automatic logic [2:0] path_st(input logic [5:0] op, input int i);
        case (i)
            0: return S_IF;
            1: return S_ID;
            2: return S_EXE;
            3: return (op == SW || op == LW) ? S_MEM : S_WB;
            default: return S_WB;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            SUB, BEQ: return 3'd1;
            OR_, ORI: return 3'd2;
            AND_:     return 3'd3;
            SLL:      return 3'd4;
            SLT:      return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctl(input logic [5:0] op, input logic [2:0] st,
                                            input logic z, input bit last);
        logic [2:0] alu = 3'd0;
        logic pcw = 1'b0, irw = 1'b0, rw = 1'b0, srcb = 1'b0, mw = 1'b0;
        logic dbs = 1'b0, wrd = 1'b0, ext = 1'b0;
        logic [1:0] dst = 2'd0, pcs = 2'd0;
        irw = (st == S_IF);
        pcw = last && (op != HALT) && (st != S_IF) && (st != S_HALT);
        if (st == S_EXE || st == S_MEM || st == S_WB) begin
            alu  = alu_of(op);
            srcb = (op == ADDI || op == ORI || op == LW || op == SW);
            ext  = (op != ORI);
        end
        if (st == S_ID && op == J) pcs = 2'b11;
        if (st == S_ID && JAL_ON && op == JAL) begin
            rw = 1'b1; dst = 2'b00; wrd = 1'b0; pcs = 2'b11;
        end
        if (st == S_ID && JAL_ON && op == JR) pcs = 2'b10;
        if (st == S_EXE && op == BEQ && z) pcs = 2'b01;
        if (st == S_MEM && op == SW) mw = 1'b1;
        if (st == S_WB) begin
            rw = 1'b1; wrd = 1'b1; dbs = (op == LW);
            dst = rtype(op) ? 2'b10 : 2'b01;
        end
        return {alu, pcw, irw, rw, srcb, mw, dbs, wrd, dst, pcs, ext};
    endfunction

    // zmode: 0/1 drive that zero value, 2 randomize every cycle; abort_at: state index for mid-instr reset
    task automatic run_instr(input logic [5:0] op, input int zmode, input int abort_at);
        logic zv;
        int   n;
        n = path_len(op);
        bus.opcode = op;
        for (int i = 0; i < n; i++) begin
            zv = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            bus.zero = zv;
            @(negedge CLK);
            chk($sformatf("state op=%b step%0d", op, i), {13'd0, bus.state}, {13'd0, path_st(op, i)});
            chk($sformatf("ctl op=%b step%0d z=%b", op, i, zv), {1'b0, observed_ctl()},
                {1'b0, exp_ctl(op, path_st(op, i), zv, i == n - 1)});
            if (i == abort_at) begin
                #2 RST = 1'b1;
                #1;
                chk("midinstr_rst_state", {13'd0, bus.state}, {13'd0, S_IF});
                chk("midinstr_rst_pcwre", {15'd0, bus.PCWre}, 16'd0);
                @(posedge CLK);
                #1 RST = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [5:0] op;
        RST = 1'b1;
        bus.opcode = ADD;
        bus.zero = 1'b0;
        #1;
        chk("rst_state", {13'd0, bus.state}, {13'd0, S_IF});
        chk("rst_pcwre", {15'd0, bus.PCWre}, 16'd0);
        chk("rst_regwre", {15'd0, bus.RegWre}, 16'd0);
        chk("rst_memrw", {15'd0, bus.DataMemRW}, 16'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_state", {13'd0, bus.state}, {13'd0, S_IF});
        RST = 1'b0;

        // directed instruction mix
        run_instr(ADD, 0, -1);
        run_instr(LW, 1, -1);
        run_instr(SW, 0, -1);
        run_instr(BEQ, 1, -1);
        run_instr(BEQ, 0, -1);
        run_instr(ORI, 1, -1);
        run_instr(JAL, 0, -1);
        run_instr(JR, 0, -1);
        run_instr(J, 1, -1);
        run_instr(6'b101010, 1, -1);
        run_instr(LW, 0, 2);
        run_instr(SLT, 2, -1);

        // random opcode and zero stream
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 6'($urandom_range(0, 62));
            end else begin
                op = OPS[int'($urandom_range(0, 13))];
            end
            run_instr(op, 2, -1);
        end

        // halt: sticky until reset, reset from HALT needs no clock edge
        run_instr(HALT, 2, -1);
        repeat (10) begin
            bus.zero = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("halt_state", {13'd0, bus.state}, {13'd0, S_HALT});
            chk("halt_ctl", {1'b0, observed_ctl()}, 16'd0);
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("halt_rst_state", {13'd0, bus.state}, {13'd0, S_IF});
        chk("halt_rst_pcwre", {15'd0, bus.PCWre}, 16'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        run_instr(ADDI, 2, -1);
        run_instr(AND_, 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, asynchronous, active-high; one clock domain only.
REQ-003 opcode  input  6  instruction opcode, held stable by the instruction register from the end of IF.
REQ-004 zero  input  1  ALU zero flag; valid combinationally during EXE.
REQ-005 ALUOp  output  3  ALU operation select.
  - 000 add
  - 001 sub
  - 010 or
  - 011 and
  - 100 sll
  - 101 slt
REQ-006 PCWre  output  1  PC write enable.
REQ-007 IRWre  output  1  instruction register write enable.
REQ-008 RegWre  output  1  register file write enable.
REQ-009 ALUSrcB  output  1  ALU B operand select: 0 = register, 1 = extended immediate.
REQ-010 DataMemRW  output  1  data memory direction: 0 = read, 1 = write.
REQ-011 DBDataSrc  output  1  writeback source: 0 = ALU result, 1 = memory.
REQ-012 WrRegData  output  1  writeback source: 0 = PC+4, 1 = DB.
REQ-013 RegDst  output  2  destination register: 00 = $31, 01 = rt, 10 = rd.
REQ-014 PCSrc  output  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = register rs, 11 = jump target.
REQ-015 ExtSel  output  1  immediate extension: 1 = sign, 0 = zero.
REQ-016 state  output  3  current FSM state, for debug and the bench.

Function
REQ-017 The FSM SHALL have six states: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. The state register updates on the rising edge of CLK.
REQ-018 Opcodes SHALL be:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010
  - sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, halt 111111
REQ-019 State transitions SHALL be:
  - IF->ID always.
  - ID->IF for j and for illegal opcodes; ID->HALT for halt; ID->EXE for all other opcodes.
  - EXE->IF for beq; EXE->MEM for sw/lw; EXE->WB for all other opcodes.
  - MEM->IF for sw; MEM->WB for lw.
  - WB->IF always.
  - HALT->HALT until reset.
REQ-020 All outputs SHALL be combinational decodes of the current state and opcode, with zero latency. Every signal not named as asserted SHALL be 0.
REQ-021 IRWre SHALL be 1 only in IF.
REQ-022 PCWre SHALL be 1 only in the last state of each instruction: ID for j/illegal, EXE for beq, MEM for sw, WB otherwise. It SHALL be 0 in IF and HALT.
REQ-023 ALUOp and ALUSrcB SHALL be driven from opcode in EXE, MEM and WB, so the ALU result stays stable through writeback.
  - beq: ALUOp=sub.
  - addi/ori/lw/sw: ALUSrcB=1.
  - ExtSel=0 only for ori.
REQ-024 beq: PCSrc=01 in EXE when zero=1, else 00. zero SHALL be ignored in all other states and for all other opcodes.
REQ-025 j: PCSrc=11 in ID.
REQ-026 RegWre SHALL be 1 only in WB. RegDst=10 for R-type, 01 for addi/ori/lw. DBDataSrc=1 and WrRegData=1 for lw; WrRegData=1 for all other writebacks.
REQ-027 DataMemRW SHALL be 1 only in MEM for sw.
REQ-028 Illegal opcodes SHALL execute as a two-cycle nop (IF, ID) with no register or memory write.
REQ-029 An opcode change outside IF is a don't-care for the design; the bench SHALL hold opcode stable.

Reset
REQ-030 While RST=1, state SHALL be IF and PCWre=0. Reset SHALL take effect immediately, including mid-instruction and from HALT.
REQ-031 The first rising edge of CLK after RST deasserts SHALL move IF->ID.

Configuration
REQ-032 With CTRL_JAL_EN defined, the following opcodes SHALL be decoded:
  - jal 111010: ID->IF; in ID, RegWre=1, RegDst=00, WrRegData=0, PCSrc=11, PCWre=1.
  - jr 111001: ID->IF; in ID, PCSrc=10, PCWre=1.
REQ-033 Without CTRL_JAL_EN, jal and jr SHALL be treated as illegal opcodes (nop per REQ-028).

Structure
REQ-034 A shared package SHALL hold the state encodings, the opcode constants and the ALUOp constants; the ALU SHALL use the same ALUOp constants.
REQ-035 One sub-module, ctrl_decode, SHALL contain the combinational output decode; multi_cycle_ctrl SHALL contain only the state register and next-state logic.

Verification
REQ-036 Pulse RST for 2 cycles -> state=IF, PCWre=0, RegWre=0, DataMemRW=0.
REQ-037 opcode=000000 (add) -> state sequence IF,ID,EXE,WB,IF; in WB, RegWre=1, RegDst=10, ALUOp=000, PCWre=1.
REQ-038 opcode=110001 (lw) -> IF,ID,EXE,MEM,WB; in WB, DBDataSrc=1, RegDst=01, ALUSrcB=1. opcode=110000 (sw) -> DataMemRW=1 in MEM, then IF.
REQ-039 opcode=110100 (beq) with zero=1 in EXE -> PCSrc=01, ALUOp=001. Repeat with zero=0 -> PCSrc=00. Both cases take 3 cycles.
REQ-040 opcode=111111 (halt) -> HALT held for 10 cycles with PCWre=0. RST asserted mid-HALT -> IF immediately, with no clock edge required.
REQ-041 opcode=111010 (jal) -> with CTRL_JAL_EN: ID asserts RegWre=1, RegDst=00, PCSrc=11. Without CTRL_JAL_EN: nop with RegWre=0.
